// File: rtl/bcd_event_counter_ctrl_if.sv
// Command/status bundle for the BCD event counter controller.
// The master issues command pulses and the slave returns the packed BCD count and status.
interface bcd_event_counter_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  stop;
  logic                  sclr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  tick;
  logic [4*DIGITS-1:0]   count;
  logic                  carry;
  logic                  ovf;
  logic                  running;
  logic                  done;
  logic                  load_err;

  modport master (
    output start,
    output stop,
    output sclr,
    output load,
    output load_val,
    output tick,
    input  count,
    input  carry,
    input  ovf,
    input  running,
    input  done,
    input  load_err
  );

  modport slave (
    input  start,
    input  stop,
    input  sclr,
    input  load,
    input  load_val,
    input  tick,
    output count,
    output carry,
    output ovf,
    output running,
    output done,
    output load_err
  );
endinterface

// File: rtl/bcd_event_counter_ctrl.sv
// Run/hold controller around a synchronous multi-digit BCD count chain.
// WRAP selects between roll-over with a carry pulse and saturation into DONE.
module bcd_event_counter_ctrl #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                      clk,
  input  logic                      clr,
  bcd_event_counter_ctrl_if.slave   s
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_count;
  logic            r_carry;
  logic            r_ovf;
  logic            r_load_err;

  logic [DIGITS:0]   w_en;
  logic [DIGITS-1:0] w_is9;
  logic [DIGITS-1:0] w_nx9;
  logic [DIGITS-1:0] w_ld_ok;
  logic [W-1:0]      w_next;
  logic              w_all9;
  logic              w_next_all9;
  logic              w_load_ok;
  logic              w_in_run;
  logic              w_can_start;

  // w_en[i]: digit i advances when every lower digit sits at 9.
  assign w_en[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [3:0] w_d;
    assign w_d = r_count[4*g +: 4];
    assign w_is9[g] = (w_d == 4'd9);
    assign w_en[g+1] = w_en[g] & w_is9[g];
    assign w_ld_ok[g] = (s.load_val[4*g +: 4] <= 4'd9);
    always_comb begin
      w_next[4*g +: 4] = w_d;
      if (w_en[g]) begin
        w_next[4*g +: 4] = w_is9[g] ? 4'd0 : w_d + 4'd1;
      end
    end
    assign w_nx9[g] = (w_next[4*g +: 4] == 4'd9);
  end

  assign w_all9      = w_en[DIGITS];
  assign w_next_all9 = &w_nx9;
  assign w_load_ok   = &w_ld_ok;
  assign w_in_run    = (r_state == S_RUN);
  assign w_can_start = (r_state == S_IDLE) ||
                       (r_state == S_HOLD);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
      if (s.sclr) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (s.load && !w_in_run) begin
        if (w_load_ok) begin
          r_count <= s.load_val;
          r_ovf   <= 1'b0;
          r_state <= S_HOLD;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (s.stop) begin
        // stop always consumes the cycle, so a same-cycle tick or start is lost
        if (w_in_run) begin
          r_state <= S_HOLD;
        end
      end else if (s.start && w_can_start) begin
        r_state <= S_RUN;
      end else if (s.tick && w_in_run) begin
        if (WRAP) begin
          r_count <= w_next;
          if (w_all9) begin
            r_carry <= 1'b1;
            r_ovf   <= 1'b1;
          end
        end else if (w_all9) begin
          r_state <= S_DONE;
        end else begin
          r_count <= w_next;
          if (w_next_all9) begin
            r_state <= S_DONE;
          end
        end
      end
    end
  end

  assign s.count    = r_count;
  assign s.carry    = r_carry;
  assign s.ovf      = r_ovf;
  assign s.load_err = r_load_err;
  assign s.running  = (r_state == S_RUN);
  assign s.done     = WRAP ? 1'b0 : (r_state == S_DONE);

endmodule

// File: tb/tb_bcd_event_counter_ctrl.sv
// Directed bench: a WRAP=1 instance (a) and a WRAP=0 instance (b).
// Each task drives one scenario and checks hand-computed values.
module tb_bcd_event_counter_ctrl;

  logic clk;
  logic clr;
  int   errs;
  int   nchk;

  bcd_event_counter_ctrl_if #(.DIGITS(4)) a ();
  bcd_event_counter_ctrl_if #(.DIGITS(4)) b ();

  bcd_event_counter_ctrl #(.DIGITS(4), .WRAP(1'b1)) u_a (
    .clk (clk),
    .clr (clr),
    .s   (a.slave)
  );

  bcd_event_counter_ctrl #(.DIGITS(4), .WRAP(1'b0)) u_b (
    .clk (clk),
    .clr (clr),
    .s   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_a();
    a.start = 0; a.stop = 0; a.sclr = 0;
    a.load = 0; a.tick = 0; a.load_val = '0;
  endtask

  task automatic idle_b();
    b.start = 0; b.stop = 0; b.sclr = 0;
    b.load = 0; b.tick = 0; b.load_val = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 0;
    a.start = 1; a.tick = 1; a.load = 1;
    a.load_val = 16'h1234;
    b.start = 1; b.tick = 1; b.load = 1;
    b.load_val = 16'h5678;
    #3;
    nchk++; if (a.count !== 16'h0000) begin errs++; $display("FAIL rst_count act=%h exp=%h", a.count, 16'h0000); end
    nchk++; if (a.running !== 1'b0) begin errs++; $display("FAIL rst_running act=%b exp=0", a.running); end
    nchk++; if (a.ovf !== 1'b0 || a.carry !== 1'b0) begin errs++; $display("FAIL rst_ovf_carry act=%b%b exp=00", a.ovf, a.carry); end
    nchk++; if (b.done !== 1'b0 || b.count !== 16'h0000) begin errs++; $display("FAIL rst_b act=%b/%h exp=0/0000", b.done, b.count); end
    idle_a();
    idle_b();
    @(negedge clk);
    clr = 1;
    repeat (5) cyc();
    nchk++; if (a.count !== 16'h0000 || a.running !== 1'b0) begin errs++; $display("FAIL rst_hold act=%h/%b exp=0000/0", a.count, a.running); end
  endtask

  task automatic test_run_count();
    a.start = 1; cyc(); a.start = 0;
    a.tick = 1; repeat (25) cyc(); a.tick = 0;
    nchk++; if (a.count !== 16'h0025) begin errs++; $display("FAIL run25 act=%h exp=%h", a.count, 16'h0025); end
    nchk++; if (a.running !== 1'b1) begin errs++; $display("FAIL run_running act=%b exp=1", a.running); end
    a.stop = 1; a.tick = 1; cyc(); a.stop = 0; a.tick = 0;
    nchk++; if (a.count !== 16'h0025 || a.running !== 1'b0) begin errs++; $display("FAIL stop_tick act=%h/%b exp=0025/0", a.count, a.running); end
    a.start = 1; a.tick = 1; cyc(); a.start = 0;
    cyc(); a.tick = 0;
    nchk++; if (a.count !== 16'h0026) begin errs++; $display("FAIL restart act=%h exp=%h", a.count, 16'h0026); end
  endtask

  task automatic test_decade_carry();
    a.stop = 1; cyc(); a.stop = 0;
    a.load = 1; a.load_val = 16'h0999; cyc(); a.load = 0;
    nchk++; if (a.count !== 16'h0999 || a.running !== 1'b0) begin errs++; $display("FAIL load999 act=%h/%b exp=0999/0", a.count, a.running); end
    a.start = 1; cyc(); a.start = 0;
    a.tick = 1; cyc(); a.tick = 0;
    nchk++; if (a.count !== 16'h1000) begin errs++; $display("FAIL ripple act=%h exp=%h", a.count, 16'h1000); end
    a.stop = 1; cyc(); a.stop = 0;
    a.load = 1; a.load_val = 16'h9999; cyc(); a.load = 0;
    a.start = 1; cyc(); a.start = 0;
    nchk++; if (a.carry !== 1'b0) begin errs++; $display("FAIL carry_early act=%b exp=0", a.carry); end
    a.tick = 1; cyc(); a.tick = 0;
    nchk++; if (a.count !== 16'h0000) begin errs++; $display("FAIL wrap_count act=%h exp=%h", a.count, 16'h0000); end
    nchk++; if (a.carry !== 1'b1 || a.ovf !== 1'b1) begin errs++; $display("FAIL wrap_flags act=%b%b exp=11", a.carry, a.ovf); end
    nchk++; if (a.running !== 1'b1) begin errs++; $display("FAIL wrap_run act=%b exp=1", a.running); end
    cyc();
    nchk++; if (a.carry !== 1'b0 || a.ovf !== 1'b1) begin errs++; $display("FAIL carry_pulse act=%b%b exp=01", a.carry, a.ovf); end
    a.sclr = 1; cyc(); a.sclr = 0;
    nchk++; if (a.ovf !== 1'b0 || a.running !== 1'b0) begin errs++; $display("FAIL sclr_ovf act=%b/%b exp=0/0", a.ovf, a.running); end
  endtask

  task automatic test_saturate();
    b.load = 1; b.load_val = 16'h9998; cyc(); b.load = 0;
    b.start = 1; cyc(); b.start = 0;
    b.tick = 1; repeat (3) cyc(); b.tick = 0;
    nchk++; if (b.count !== 16'h9999) begin errs++; $display("FAIL sat_count act=%h exp=%h", b.count, 16'h9999); end
    nchk++; if (b.done !== 1'b1 || b.running !== 1'b0) begin errs++; $display("FAIL sat_state act=%b/%b exp=1/0", b.done, b.running); end
    nchk++; if (b.carry !== 1'b0 || b.ovf !== 1'b0) begin errs++; $display("FAIL sat_flags act=%b%b exp=00", b.carry, b.ovf); end
    b.start = 1; cyc(); b.start = 0;
    nchk++; if (b.done !== 1'b1 || b.running !== 1'b0) begin errs++; $display("FAIL sat_start act=%b/%b exp=1/0", b.done, b.running); end
    b.load = 1; b.load_val = 16'h0100; cyc(); b.load = 0;
    nchk++; if (b.count !== 16'h0100 || b.done !== 1'b0) begin errs++; $display("FAIL sat_exit act=%h/%b exp=0100/0", b.count, b.done); end
  endtask

  task automatic test_load_rules();
    a.load = 1; a.load_val = 16'h0500; cyc(); a.load = 0;
    a.load = 1; a.load_val = 16'h12A4; cyc(); a.load = 0;
    nchk++; if (a.load_err !== 1'b1 || a.count !== 16'h0500) begin errs++; $display("FAIL bad_load act=%b/%h exp=1/0500", a.load_err, a.count); end
    cyc();
    nchk++; if (a.load_err !== 1'b0) begin errs++; $display("FAIL err_pulse act=%b exp=0", a.load_err); end
    a.start = 1; cyc(); a.start = 0;
    a.load = 1; a.load_val = 16'h4321; cyc(); a.load = 0;
    nchk++; if (a.count !== 16'h0500 || a.load_err !== 1'b0 || a.running !== 1'b1) begin errs++; $display("FAIL run_load act=%h/%b/%b exp=0500/0/1", a.count, a.load_err, a.running); end
    a.sclr = 1; a.load = 1; a.start = 1; a.load_val = 16'h0077; cyc();
    idle_a();
    nchk++; if (a.count !== 16'h0000 || a.running !== 1'b0) begin errs++; $display("FAIL sclr_prio act=%h/%b exp=0000/0", a.count, a.running); end
    a.tick = 1; cyc(); a.tick = 0;
    nchk++; if (a.count !== 16'h0000) begin errs++; $display("FAIL idle_tick act=%h exp=0000", a.count); end
  endtask

  task automatic test_async_clr();
    a.load = 1; a.load_val = 16'h0457; cyc(); a.load = 0;
    a.start = 1; cyc(); a.start = 0;
    nchk++; if (a.count !== 16'h0457 || a.running !== 1'b1) begin errs++; $display("FAIL pre_clr act=%h/%b exp=0457/1", a.count, a.running); end
    a.tick = 1;
    @(posedge clk); #2;
    clr = 0;
    #1;
    nchk++; if (a.count !== 16'h0000 || a.running !== 1'b0) begin errs++; $display("FAIL async_clr act=%h/%b exp=0000/0", a.count, a.running); end
    @(negedge clk);
    clr = 1;
    repeat (3) cyc();
    a.tick = 0;
    nchk++; if (a.count !== 16'h0000 || a.running !== 1'b0) begin errs++; $display("FAIL post_clr act=%h/%b exp=0000/0", a.count, a.running); end
    a.start = 1; cyc(); a.start = 0;
    a.tick = 1; repeat (2) cyc(); a.tick = 0;
    nchk++; if (a.count !== 16'h0002) begin errs++; $display("FAIL after_start act=%h exp=0002", a.count); end
  endtask

  initial begin
    errs = 0;
    nchk = 0;
    idle_a();
    idle_b();
    test_reset();
    test_run_count();
    test_decade_carry();
    test_saturate();
    test_load_rules();
    test_async_clr();
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/bcd_event_counter_ctrl.md
# bcd_event_counter_ctrl

Controller that owns a multi-digit synchronous BCD (decade) count chain and sequences it from start/stop/clear/load commands. Each digit counts 0–9 and ripples its carry into the next digit within the same clock edge. The block lets the rest of the design treat the chain as a run/hold event counter with preset load, terminal-count reporting and selectable wrap or saturate behaviour. It sits between the control plane (command pulses) and the display/readout logic that consumes the packed BCD value.

## Interface
- DIGITS, 4, number of BCD digits (1–8)
- WRAP, 1, 1: wrap all-9s→all-0s and set ovf; 0: stop at all-9s and enter DONE
- clk  in  1  clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-low; clears every register
- start  in  1  command: enter RUN
- stop  in  1  command: leave RUN, enter HOLD
- sclr  in  1  synchronous clear: count to 0, ovf to 0, state to IDLE
- load  in  1  preset request (honoured only outside RUN)
- load_val  in  4*DIGITS  preset value, digit 0 in [3:0]
- tick  in  1  count event, one increment per cycle high while RUN
- count  out  4*DIGITS  registered BCD value, digit 0 in [3:0]
- carry  out  1  registered one-cycle pulse on all-9s→all-0s roll (WRAP=1)
- ovf  out  1  sticky overflow, set with carry, cleared by sclr/load/clr
- running  out  1  state==RUN
- done  out  1  state==DONE (WRAP=0 only; tied 0 when WRAP=1)
- load_err  out  1  one-cycle pulse: load rejected because a load_val digit >9

## Operation
- States: IDLE, RUN, HOLD, DONE. Encoding free; only running/done exported.
- Per-cycle command priority: sclr > load > stop > start > tick.
- sclr (any state): count=0, ovf=0, state=IDLE; other inputs that cycle ignored.
- load in IDLE/HOLD/DONE: if every digit of load_val ≤9 → count=load_val, ovf=0, state=HOLD; else count unchanged, state unchanged, load_err=1 for one cycle. load in RUN: ignored, no load_err.
- stop in RUN → HOLD; tick in the same cycle is dropped. stop elsewhere: no effect.
- start in IDLE/HOLD → RUN. start in DONE or RUN: no effect. start with stop same cycle: stop wins (state unchanged if not RUN).
- tick in RUN: increment. Digit i increments when tick and digits 0..i-1 are all 9; a digit at 9 that increments goes to 0. Digits never hold values >9.
- Roll from all-9s, WRAP=1: count→0, carry=1 next cycle, ovf=1, stay RUN.
- WRAP=0: tick that makes count all-9s → state DONE same edge; in DONE ticks ignored, count frozen at all-9s, carry never asserted. Exit DONE only via sclr, load or clr.
- tick outside RUN: ignored.

## Timing
- Reset (clr low, async): count=0, carry=0, ovf=0, running=0, done=0, load_err=0, state=IDLE. Outputs valid immediately on clr assertion; first command accepted at first rising edge after clr deasserts.
- All outputs registered; no combinational input→output paths.
- Command at edge N → state/count visible after edge N. start at edge N: RUN after N; tick sampled at edge N is ignored (not yet RUN); first counted tick at edge N+1.
- Increment latency 1 cycle; full-chain carry resolves in one edge for any DIGITS.
- carry and load_err are single-cycle pulses, low otherwise; back-to-back rolls impossible (need 10^DIGITS ticks).
- clr asserted mid-RUN aborts immediately; no partial increment retained.

## Test plan
- Reset: drive clr=0 with random inputs → count=0x0000, running=0, done=0, ovf=0, carry=0; release, hold 5 idle cycles → unchanged.
- Run/count: start, then 25 consecutive ticks → count=0x0025, running=1; stop with tick same cycle → count stays 0x0025, state HOLD; start again, 1 tick → 0x0026.
- Decade carry: load 0x0999, start, 1 tick → 0x1000; load 0x9999 (WRAP=1), start, 1 tick → 0x0000, carry pulse 1 cycle, ovf=1 sticky until sclr.
- Saturate (WRAP=0): load 0x9998, start, 3 ticks → count 0x9999, done=1, running=0; start ignored; load 0x0100 → HOLD, done=0.
- Load rules: load 0x12A4 in HOLD → load_err pulse, count unchanged; load 0x4321 during RUN → ignored, no load_err; sclr+load+start same cycle → count 0, IDLE.
- Async reset mid-run: RUN at 0x0457, assert clr between edges → outputs zero immediately, IDLE after release, ticks ignored until start.
